// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding,
// default operand width and the bit-counter sizing rule.
package serial_add_ctrl_pkg;

    localparam int unsigned DefaultWidth = 8;

    localparam logic [1:0] IdleEnc = 2'd0;
    localparam logic [1:0] RunEnc  = 2'd1;
    localparam logic [1:0] DoneEnc = 2'd2;

    typedef enum logic [1:0] {
        StIdle = IdleEnc,
        StRun  = RunEnc,
        StDone = DoneEnc
    } state_e;

    // Counter must index WIDTH bit positions, but never shrink below one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle of the serial adder; master drives operands,
// slave (the adder) returns status and the registered result.
interface serial_add_ctrl_if
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/fulladder.sv
// One-bit full adder; the only arithmetic on the serial sum path.
module fulladder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic w_p;

    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: accepts a, b, cin in IDLE, adds one bit per RUN cycle
// LSB first through a single full adder, then pulses done for one cycle.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);

    localparam int unsigned             CntWidth = cnt_width(WIDTH);
    localparam logic [CntWidth-1:0]     LastCnt  = CntWidth'(WIDTH - 1);

    state_e              r_state;
    state_e              w_state_d;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    w_a_d;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    w_b_d;
    logic [WIDTH-1:0]    r_sum;
    logic [WIDTH-1:0]    w_sum_d;
    logic [CntWidth-1:0] r_cnt;
    logic [CntWidth-1:0] w_cnt_d;
    logic                r_carry;
    logic                w_carry_d;
    logic                r_cout;
    logic                w_cout_d;
    logic                r_busy;
    logic                r_done;
    logic                w_fa_s;
    logic                w_fa_c;

    fulladder u_fa (
        .i_a (r_a[0]),
        .i_b (r_b[0]),
        .i_c (r_carry),
        .o_s (w_fa_s),
        .o_c (w_fa_c)
    );

    always_comb begin
        w_state_d = r_state;
        w_a_d     = r_a;
        w_b_d     = r_b;
        w_sum_d   = r_sum;
        w_cnt_d   = r_cnt;
        w_carry_d = r_carry;
        w_cout_d  = r_cout;
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_a_d     = bus.a;
                    w_b_d     = bus.b;
                    w_carry_d = bus.cin;
                    w_cnt_d   = '0;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_a_d     = r_a >> 1;
                w_b_d     = r_b >> 1;
                // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                w_sum_d   = (r_sum >> 1) | (WIDTH'(w_fa_s) << (WIDTH - 1));
                w_carry_d = w_fa_c;
                w_cnt_d   = r_cnt + 1'b1;
                if (r_cnt == LastCnt) begin
                    w_cout_d  = w_fa_c;
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_a     <= w_a_d;
            r_b     <= w_b_d;
            r_sum   <= w_sum_d;
            r_cnt   <= w_cnt_d;
            r_carry <= w_carry_d;
            r_cout  <= w_cout_d;
            // Status flops track the next state so they line up with r_state.
            r_busy  <= (w_state_d != StIdle);
            r_done  <= (w_state_d == StDone);
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: vector table at WIDTH=8 plus
// hand-written sequences for mid-run start, reset abort, held start and WIDTH=1.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs [8];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int wide_cnt = 0;
    logic prev_done = 1'b0;

    // Count done pulses and any pulse lasting more than one cycle.
    always @(negedge clk) begin
        if (bus8.done === 1'b1) begin
            done_cnt++;
            if (prev_done === 1'b1) wide_cnt++;
        end
        prev_done = bus8.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycle 0 presents start; done is expected in cycle WIDTH+1.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] es, input logic ec, input string tag);
        int n;
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = cin;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.a     = ~a;
        bus8.b     = ~b;
        bus8.cin   = ~cin;
        check($sformatf("%s busy", tag), 32'(bus8.busy), 32'd1);
        n = 1;
        while (bus8.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check($sformatf("%s latency", tag), n, 32'd9);
        check($sformatf("%s sum", tag), 32'(bus8.sum), 32'(es));
        check($sformatf("%s cout", tag), 32'(bus8.cout), 32'(ec));
        tick();
        check($sformatf("%s done_low", tag), 32'(bus8.done), 32'd0);
        check($sformatf("%s idle", tag), 32'(bus8.busy), 32'd0);
        check($sformatf("%s sum_hold", tag), 32'(bus8.sum), 32'(es));
    endtask

    task automatic run1(input logic a, input logic b, input logic cin,
                        input logic es, input logic ec, input string tag);
        int n;
        bus1.a     = a;
        bus1.b     = b;
        bus1.cin   = cin;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        n = 1;
        while (bus1.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("%s latency", tag), n, 32'd2);
        check($sformatf("%s sum", tag), 32'(bus1.sum), 32'(es));
        check($sformatf("%s cout", tag), 32'(bus1.cout), 32'(ec));
        tick();
        check($sformatf("%s done_low", tag), 32'(bus1.done), 32'd0);
    endtask

    initial begin
        int n;
        int d0;
        int w0;
        int na;
        int accepts [4];
        logic prev_busy;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, sum: 8'h96, cout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b1, sum: 8'h01, cout: 1'b1};
        vecs[5] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, sum: 8'h00, cout: 1'b1};
        vecs[6] = '{a: 8'h12, b: 8'h34, cin: 1'b1, sum: 8'h47, cout: 1'b0};
        vecs[7] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0};

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;

        repeat (3) tick();
        check("rst busy", 32'(bus8.busy), 32'd0);
        check("rst done", 32'(bus8.done), 32'd0);
        check("rst sum", 32'(bus8.sum), 32'd0);
        check("rst cout", 32'(bus8.cout), 32'd0);
        check("rst w1 busy", 32'(bus1.busy), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
                 $sformatf("vec%0d", i));
        end

        // Start pulsed in RUN cycle 3 with new operands must be ignored.
        d0 = done_cnt;
        bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        bus8.start = 1'b1; bus8.a = 8'h11; bus8.b = 8'h11;
        tick();
        bus8.start = 1'b0;
        n = 4;
        while (bus8.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("midstart latency", n, 32'd9);
        check("midstart sum", 32'(bus8.sum), 32'h46);
        repeat (12) tick();
        check("midstart pulses", done_cnt - d0, 32'd1);
        check("midstart idle", 32'(bus8.busy), 32'd0);

        // Asynchronous reset in RUN cycle 4 aborts without a done pulse.
        run8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "prerst");
        d0 = done_cnt;
        bus8.a = 8'hF0; bus8.b = 8'h0F; bus8.cin = 1'b1; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        repeat (3) tick();
        check("abort running", 32'(bus8.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(bus8.busy), 32'd0);
        check("abort sum", 32'(bus8.sum), 32'd0);
        check("abort cout", 32'(bus8.cout), 32'd0);
        check("abort done", 32'(bus8.done), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("abort no_done", done_cnt - d0, 32'd0);
        run8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "postrst");

        // Start held high for 30 cycles: accepts every WIDTH+2 cycles.
        d0 = done_cnt;
        w0 = wide_cnt;
        na = 0;
        prev_busy = bus8.busy;
        bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 30) bus8.start = 1'b0;
            if (bus8.busy === 1'b1 && prev_busy !== 1'b1 && na < 4) begin
                accepts[na] = c;
                na++;
            end
            prev_busy = bus8.busy;
        end
        check("held accepts", na, 32'd3);
        check("held gap1", accepts[1] - accepts[0], 32'd10);
        check("held gap2", accepts[2] - accepts[1], 32'd10);
        check("held pulses", done_cnt - d0, 32'd3);
        check("held width", wide_cnt - w0, 32'd0);
        check("held sum", 32'(bus8.sum), 32'h02);
        tick();
        check("held idle", 32'(bus8.busy), 32'd0);

        run1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "w1 111");
        run1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "w1 100");
        run1(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "w1 001");
        run1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "w1 000");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
